// File: rtl/sequence_game_ctrl_pkg.sv
// Shared definitions for the memory-sequence game.
// Holds the controller state encoding, the default game parameters and a
// small width helper. The top level and the digit buffer import it, and so
// can the external two-digit timer, so everyone agrees on level and state widths.
package sequence_game_ctrl_pkg;

  // Game phases: wait for a start, fill the sequence, show it, collect it, finished
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW,
    ST_INPUT,
    ST_DONE
  } game_state_t;

  localparam int DEF_DIGIT_W  = 4;
  localparam int DEF_BASE_LEN = 3;
  localparam int DEF_MAX_LEN  = 8;
  localparam int DEF_LEVELS   = 4;
  localparam int DEF_SCORE_W  = 7;

  // clog2 that never collapses to a zero-width bus
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sequence_game_ctrl_seq_buffer.sv
// seq_buffer: storage for the digits of the current game sequence.
// Ports:
//   clk      - system clock
//   wr_en    - write strobe, asserted while the controller is loading
//   wr_addr  - slot written when wr_en is high
//   wr_data  - digit written into wr_addr
//   rd_addr  - slot being shown or compared against
//   rd_data  - contents of rd_addr, available in the same cycle
// The contents are never reset: every slot that gets read in a game is
// written during that game's LOAD phase first.
module seq_buffer
  import sequence_game_ctrl_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int ADDR_W  = safe_clog2(DEF_MAX_LEN)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DIGIT_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DIGIT_W-1:0] rd_data
);

  logic [DIGIT_W-1:0] mem [MAX_LEN];

  // Single write port, filled one digit per cycle while loading
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read so SHOW and INPUT see the digit at idx in the same cycle
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sequence_game_ctrl.sv
// sequence_game_ctrl: controller for a "repeat the sequence" memory game.
// Each level loads BASE_LEN+level random digits, shows them one per
// show_tick, then lets the player re-enter them before the timer expires.
// Ports:
//   clk, rst        - clock and synchronous active-low reset
//   logged_in       - authentication level; low sends the game back to IDLE
//   start           - begin / restart a game (honoured in IDLE and DONE)
//   enter           - user_digit is valid this cycle
//   user_digit      - digit typed by the player
//   rand_digit      - random digit captured once per LOAD cycle
//   show_tick       - pacing pulse that steps through the shown sequence
//   timeout         - player ran out of time
//   timer_reconfig  - one-cycle pulse reloading the timer as INPUT begins
//   timer_enable    - high while the player is entering digits
//   game_level      - current level
//   rand_disp       - digit being shown during SHOW, else 0
//   player_disp     - last digit accepted from the player
//   score           - saturating count of correct digits
//   game_over       - game has ended
//   game_won        - game ended after clearing the final level
module sequence_game_ctrl
  import sequence_game_ctrl_pkg::*;
#(
  parameter int  DIGIT_W  = DEF_DIGIT_W,
  parameter int  BASE_LEN = DEF_BASE_LEN,
  parameter int  MAX_LEN  = DEF_MAX_LEN,
  parameter int  LEVELS   = DEF_LEVELS,
  parameter int  SCORE_W  = DEF_SCORE_W,
  localparam int LVL_W    = safe_clog2(LEVELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               logged_in,
  input  logic               start,
  input  logic               enter,
  input  logic [DIGIT_W-1:0] user_digit,
  input  logic [DIGIT_W-1:0] rand_digit,
  input  logic               show_tick,
  input  logic               timeout,
  output logic               timer_reconfig,
  output logic               timer_enable,
  output logic [LVL_W-1:0]   game_level,
  output logic [DIGIT_W-1:0] rand_disp,
  output logic [DIGIT_W-1:0] player_disp,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               game_won
);

  localparam int IDX_W = safe_clog2(MAX_LEN);

  game_state_t        state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last_idx;
  logic [DIGIT_W-1:0] rd_data;
  logic               wr_en;
  logic               digit_match;

  // Index of the final digit of this level's sequence (len - 1)
  assign last_idx    = IDX_W'(BASE_LEN - 1) + IDX_W'(game_level);
  assign wr_en       = (state == ST_LOAD);
  assign digit_match = (user_digit == rd_data);

  // The shown digit comes straight from the buffer read port so it tracks idx
  // without an extra cycle of lag; it is forced to 0 outside SHOW.
  assign rand_disp = (state == ST_SHOW) ? rd_data : '0;

  seq_buffer #(
    .DIGIT_W (DIGIT_W),
    .MAX_LEN (MAX_LEN),
    .ADDR_W  (IDX_W)
  ) u_seq_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (idx),
    .wr_data (rand_digit),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  // Main game FSM. Reset and a dropped login share one path so both leave
  // every output at 0. timer_reconfig defaults low so it is only ever a
  // single-cycle pulse on the SHOW -> INPUT transition.
  always_ff @(posedge clk) begin
    if (!rst || !logged_in) begin
      state          <= ST_IDLE;
      idx            <= '0;
      game_level     <= '0;
      score          <= '0;
      player_disp    <= '0;
      timer_reconfig <= 1'b0;
      timer_enable   <= 1'b0;
      game_over      <= 1'b0;
      game_won       <= 1'b0;
    end else begin
      timer_reconfig <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_LOAD;
            idx        <= '0;
            game_level <= '0;
            score      <= '0;
            game_over  <= 1'b0;
            game_won   <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (idx == last_idx) begin
            state <= ST_SHOW;
            idx   <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        ST_SHOW: begin
          if (show_tick) begin
            if (idx == last_idx) begin
              state          <= ST_INPUT;
              idx            <= '0;
              timer_reconfig <= 1'b1;
              timer_enable   <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        ST_INPUT: begin
          // A timeout beats a simultaneous entry; that digit is dropped
          if (timeout) begin
            state        <= ST_DONE;
            timer_enable <= 1'b0;
            game_over    <= 1'b1;
            game_won     <= 1'b0;
          end else if (enter) begin
            player_disp <= user_digit;
            if (!digit_match) begin
              state        <= ST_DONE;
              timer_enable <= 1'b0;
              game_over    <= 1'b1;
              game_won     <= 1'b0;
            end else begin
              if (score != {SCORE_W{1'b1}}) begin
                score <= score + SCORE_W'(1);
              end
              if (idx == last_idx) begin
                idx          <= '0;
                timer_enable <= 1'b0;
                if (game_level < LVL_W'(LEVELS - 1)) begin
                  game_level <= game_level + LVL_W'(1);
                  state      <= ST_LOAD;
                end else begin
                  state     <= ST_DONE;
                  game_over <= 1'b1;
                  game_won  <= 1'b1;
                end
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule
